// File: rtl/led_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : led_scan_display
// Purpose  : Displays the CPU's syscall-34 value or one of its performance
//            counters as 8 hex digits on a time-multiplexed, active-low
//            seven-segment display. The value is snapshotted once per frame
//            so that one frame never mixes digits from two values.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SCAN_DIV            clk cycles per digit slot (2 .. 2^24)
// Ports
//   clk                 system clock (shared with the CPU)
//   rst                 asynchronous, active-high reset
//   led_cpu_enable      syscall-34 strobe, level-sampled
//   led_data_in[31:0]   value latched while led_cpu_enable is high
//   total_cycles[31:0]  CPU cycle counter
//   condi_branch_num    CPU conditional-branch counter
//   uncondi_branch_num  CPU unconditional-branch counter
//   disp_sel[1:0]       0 latched value, 1 cycles, 2 cond br, 3 uncond br
//   an[7:0]             digit enables, active-low, an[0] = rightmost digit
//   seg[6:0]            segments {g,f,e,d,c,b,a}, active-low
//   dp                  decimal point, active-low
//   data_valid          set once any syscall-34 value has been latched
// Build option
//   LED_LEADING_ZERO_BLANK_EN  when defined, digits above the most
//                              significant nonzero nibble are blanked
//                              (digit 0 always shown)
// ============================================================================
module led_scan_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        led_cpu_enable,
  input  logic [31:0] led_data_in,
  input  logic [31:0] total_cycles,
  input  logic [31:0] condi_branch_num,
  input  logic [31:0] uncondi_branch_num,
  input  logic [1:0]  disp_sel,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        data_valid
);

  localparam logic [23:0] c_TICK_AT = 24'(SCAN_DIV - 1);

  logic [31:0] r_sys_val;
  logic        r_data_valid;
  logic [23:0] r_presc;
  logic [2:0]  r_idx;
  logic [31:0] r_shown;
  logic [7:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;

  logic        w_tick;
  logic        w_wrap;
  logic [2:0]  w_idx_nxt;
  logic [31:0] w_src;
  logic [31:0] w_frame;
  logic [3:0]  w_nib;
  logic [6:0]  w_seg_dec;
  logic        w_blank;
  logic [7:0]  w_an_nxt;
  logic [6:0]  w_seg_nxt;
  logic        w_dp_nxt;

  // --------------------------------------------------------------------------
  // Syscall-34 latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sys_val    <= 32'd0;
      r_data_valid <= 1'b0;
    end else if (led_cpu_enable) begin
      r_sys_val    <= led_data_in;
      r_data_valid <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Digit-slot prescaler
  // --------------------------------------------------------------------------
  assign w_tick = (r_presc == c_TICK_AT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= 24'd0;
    end else if (w_tick) begin
      r_presc <= 24'd0;
    end else begin
      r_presc <= r_presc + 24'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Source select and frame value
  // --------------------------------------------------------------------------
  always_comb begin
    w_src = r_sys_val;
    case (disp_sel)
      2'd0:    w_src = r_sys_val;
      2'd1:    w_src = total_cycles;
      2'd2:    w_src = condi_branch_num;
      default: w_src = uncondi_branch_num;
    endcase
  end

  assign w_idx_nxt = r_idx + 3'd1;
  assign w_wrap    = w_tick && (r_idx == 3'd7);

  // Digit 0 of a new frame is drawn from the value being snapshotted on the
  // same edge, so the whole frame comes from one coherent value. The latch
  // loads on that edge too, so the snapshot still sees the old r_sys_val.
  assign w_frame = (r_idx == 3'd7) ? w_src : r_shown;
  assign w_nib   = w_frame[{w_idx_nxt, 2'b00} +: 4];

  always_comb begin
    w_seg_dec = 7'h7F;
    case (w_nib)
      4'h0: w_seg_dec = 7'h40;
      4'h1: w_seg_dec = 7'h79;
      4'h2: w_seg_dec = 7'h24;
      4'h3: w_seg_dec = 7'h30;
      4'h4: w_seg_dec = 7'h19;
      4'h5: w_seg_dec = 7'h12;
      4'h6: w_seg_dec = 7'h02;
      4'h7: w_seg_dec = 7'h78;
      4'h8: w_seg_dec = 7'h00;
      4'h9: w_seg_dec = 7'h10;
      4'hA: w_seg_dec = 7'h08;
      4'hB: w_seg_dec = 7'h03;
      4'hC: w_seg_dec = 7'h46;
      4'hD: w_seg_dec = 7'h21;
      4'hE: w_seg_dec = 7'h06;
      default: w_seg_dec = 7'h0E;
    endcase
  end

`ifdef LED_LEADING_ZERO_BLANK_EN
  // Index of the most significant nonzero nibble; 0 when the value is zero,
  // which keeps digit 0 lit.
  logic [2:0] w_msn;
  always_comb begin
    w_msn = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (w_frame[4*i +: 4] != 4'h0) begin
        w_msn = 3'(i);
      end
    end
  end
  assign w_blank = (w_idx_nxt > w_msn);
`else
  assign w_blank = 1'b0;
`endif

  assign w_an_nxt  = w_blank ? 8'hFF : ~(8'd1 << w_idx_nxt);
  assign w_seg_nxt = w_blank ? 7'h7F : w_seg_dec;
  assign w_dp_nxt  = ~((w_idx_nxt == 3'd0) && (disp_sel == 2'd0) && r_data_valid);

  // --------------------------------------------------------------------------
  // Scan index, frame snapshot and output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= 3'd7;
      r_shown <= 32'd0;
      r_an    <= 8'hFF;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
    end else if (w_tick) begin
      r_idx <= w_idx_nxt;
      if (w_wrap) begin
        r_shown <= w_src;
      end
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign data_valid = r_data_valid;

endmodule
`default_nettype wire

// File: tb/tb_led_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_scan_display
// Purpose  : Scoreboard bench for led_scan_display (SCAN_DIV = 4). A
//            reference model, written in terms of elapsed cycles since reset,
//            pushes the expected display state after every clock edge; a
//            separate monitor pops and compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_scan_display;

  localparam int SD    = 4;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        led_cpu_enable = 1'b0;
  logic [31:0] led_data_in = 32'd0;
  logic [31:0] total_cycles = 32'd0;
  logic [31:0] condi_branch_num = 32'd0;
  logic [31:0] uncondi_branch_num = 32'd0;
  logic [1:0]  disp_sel = 2'd0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        data_valid;

  always #5 clk = ~clk;

  led_scan_display #(.SCAN_DIV(SD)) dut (
    .clk                (clk),
    .rst                (rst),
    .led_cpu_enable     (led_cpu_enable),
    .led_data_in        (led_data_in),
    .total_cycles       (total_cycles),
    .condi_branch_num   (condi_branch_num),
    .uncondi_branch_num (uncondi_branch_num),
    .disp_sel           (disp_sel),
    .an                 (an),
    .seg                (seg),
    .dp                 (dp),
    .data_valid         (data_valid)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       dv;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_sys;
  logic        m_valid;
  logic [31:0] m_shown;
  int          m_n;      // clock edges since reset was released
  int          m_d;
  int          m_top;
  obs_t        m_out;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] sysv);
    case (s)
      2'd0:    return sysv;
      2'd1:    return total_cycles;
      2'd2:    return condi_branch_num;
      default: return uncondi_branch_num;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_sys   = 32'd0;
      m_valid = 1'b0;
      m_shown = 32'd0;
      m_n     = 0;
      m_out   = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, dv: 1'b0};
    end else begin
      m_n = m_n + 1;
      if (m_n % SD == 0) begin
        m_d = ((m_n / SD) - 1) % 8;
        if (m_d == 0) m_shown = pick(disp_sel, m_sys);
        m_out.an        = 8'hFF;
        m_out.an[m_d]   = 1'b0;
        m_out.seg       = hex7(m_shown[4*m_d +: 4]);
        m_out.dp        = !(m_d == 0 && disp_sel == 2'd0 && m_valid);
`ifdef LED_LEADING_ZERO_BLANK_EN
        m_top = 0;
        for (int k = 1; k < 8; k++) if (m_shown[4*k +: 4] != 4'h0) m_top = k;
        if (m_d > m_top) begin
          m_out.an  = 8'hFF;
          m_out.seg = 7'h7F;
        end
`endif
      end
      if (led_cpu_enable) begin
        m_sys   = led_data_in;
        m_valid = 1'b1;
      end
      m_out.dv = m_valid;
    end
    exp_q.push_back(m_out);
  end

  // ---------------- monitor ----------------
  obs_t e;
  initial forever begin
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      if (an !== e.an || seg !== e.seg || dp !== e.dp || data_valid !== e.dv) begin
        n_bad++;
        $display("FAIL display t=%0t got an=%h seg=%h dp=%b dv=%b expected an=%h seg=%h dp=%b dv=%b",
                 $time, an, seg, dp, data_valid, e.an, e.seg, e.dp, e.dv);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    n_cmp++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || data_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s got an=%h seg=%h dp=%b dv=%b expected an=ff seg=7f dp=1 dv=0",
               tag, an, seg, dp, data_valid);
    end
  endtask

  // Asynchronous reset: outputs must clear before the next clock edge.
  task automatic do_reset(input int cycles);
    step();
    rst = 1'b1;
    #1;
    chk_reset("async_reset");
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  function automatic int cur_digit();
    if (m_n < SD) return -1;
    return ((m_n / SD) - 1) % 8;
  endfunction

  task automatic wait_digit(input int d);
    int k = 0;
    while (cur_digit() != d && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_digit timeout digit=%0d", d);
    end
  endtask

  // Leaves the bench just before the edge that carries the frame-wrap tick.
  task automatic wait_before_wrap();
    int k = 0;
    while (((m_n + 1) % FRAME) != SD && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_wrap timeout");
    end
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    chk_reset("reset_hold");
    repeat (3) step();
    rst = 1'b0;
    repeat (FRAME + 8) step();

    // Latch and display
    led_data_in    = 32'h1234ABCD;
    led_cpu_enable = 1'b1;
    step();
    led_cpu_enable = 1'b0;
    led_data_in    = 32'h0;
    repeat (2 * FRAME + 5) step();

    // Source select
    disp_sel     = 2'd1;
    total_cycles = 32'h00000010;
    repeat (2 * FRAME + 3) step();

    // Snapshot coherence
    disp_sel = 2'd0;
    repeat (FRAME) step();
    wait_digit(3);
    condi_branch_num = 32'h0BAD0F00;
    disp_sel         = 2'd2;
    repeat (2 * FRAME) step();

    // Simultaneous latch and frame boundary
    disp_sel = 2'd0;
    repeat (FRAME) step();
    wait_before_wrap();
    led_data_in    = 32'hFFFFFFFF;
    led_cpu_enable = 1'b1;
    step();
    led_cpu_enable = 1'b0;
    repeat (2 * FRAME + 2) step();

    // Mid-frame reset
    wait_digit(5);
    step();
    do_reset(2);
    repeat (FRAME + 6) step();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      total_cycles = total_cycles + 32'd1;
      if ($urandom_range(15, 0) == 0) begin
        led_cpu_enable = 1'b1;
        case ($urandom_range(3, 0))
          0:       led_data_in = 32'h0;
          1:       led_data_in = 32'h1 << ($urandom_range(31, 0));
          default: led_data_in = $urandom;
        endcase
      end else begin
        led_cpu_enable = 1'b0;
      end
      if ($urandom_range(40, 0) == 0) disp_sel = 2'($urandom_range(3, 0));
      if ($urandom_range(20, 0) == 0) condi_branch_num = $urandom >> $urandom_range(31, 0);
      if ($urandom_range(20, 0) == 0) uncondi_branch_num = $urandom >> $urandom_range(31, 0);
      if ($urandom_range(399, 0) == 0) begin
        led_cpu_enable = 1'b0;
        do_reset($urandom_range(3, 1));
      end else begin
        step();
      end
    end
    led_cpu_enable = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_scan_display.md
# led_scan_display

Display-side responder for the CPU's syscall-34 output path. Samples `led_data_in` whenever the CPU asserts `led_cpu_enable`, or selects one of the CPU's performance counters instead. Shows the selected 32-bit value as 8 hex digits on a time-multiplexed, active-low seven-segment display. Sits in the board top level between the CPU and the display pins.

## Interface

**Parameters**
- `SCAN_DIV`, default 100000: clk cycles per digit slot. Legal range is 2..2^24.

**Ports**
- `clk`, input, 1: system clock, same clock as the CPU.
- `rst`, input, 1: reset, asynchronous, active-high.
- `led_cpu_enable`, input, 1: CPU syscall-34 strobe, level-sampled.
- `led_data_in`, input, 32: value to latch while `led_cpu_enable` is high.
- `total_cycles`, input, 32: CPU cycle counter.
- `condi_branch_num`, input, 32: CPU conditional-branch counter.
- `uncondi_branch_num`, input, 32: CPU unconditional-branch counter.
- `disp_sel`, input, 2: source select.
  - 0 = latched syscall value
  - 1 = total_cycles
  - 2 = condi_branch_num
  - 3 = uncondi_branch_num
- `an`, output, 8: digit enables, active-low; `an[i]` drives digit i, and digit 0 is the rightmost.
- `seg`, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp`, output, 1: decimal point, active-low.
- `data_valid`, output, 1: high once any syscall-34 value has been latched since reset.

## Operation

**Latch register `sys_val`**
- Loads `led_data_in` on every rising clk edge where `led_cpu_enable`=1.
- Holds otherwise.
- `data_valid` sets on the same edge and stays set until `rst`.

**Prescaler**
- Counts 0..SCAN_DIV-1, then wraps to 0.
- `tick` is asserted during the cycle in which the count equals SCAN_DIV-1.

**Digit index `idx` (3 bits)**
- Advances by 1 on each tick, wrapping 7 to 0.

**Frame snapshot `shown`**
- On a tick where `idx` wraps 7 to 0, `shown` loads the source currently selected by `disp_sel`.
- Digits within one frame therefore never mix two values.
- Changes to `disp_sel` or to the counters mid-frame take effect at the next frame.

**Output register**
- On each tick, `an`, `seg` and `dp` load the pattern for the new `idx`:
  - `an` = all ones except bit `idx`, which is 0.
  - `seg` = hex decode of `shown[4*idx+3 : 4*idx]`.
  - `dp` = 0 only when `idx`=0, `disp_sel`=0 and `data_valid`=1; otherwise `dp` = 1.
- Decode values (`seg`, hex):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E

## Timing

**Reset values** (asynchronous, immediate):
- `an`=8'hFF, `seg`=7'h7F, `dp`=1, `data_valid`=0.
- Internal: `sys_val`=0, `shown`=0, prescaler=0, `idx`=7. The first tick therefore wraps `idx` to 0 and takes a snapshot.

**Latencies**
- Latch: `led_cpu_enable` sampled at edge N gives `sys_val` valid after edge N, and `data_valid` high after edge N.
- Display: a new value appears at the first frame boundary after it is latched. Worst case is 8·SCAN_DIV+1 cycles.
- First frame: all digits stay dark until the first tick, which falls SCAN_DIV cycles after `rst` deasserts. Digit 0 lights then.

**Simultaneous events**
- When `led_cpu_enable` and the frame-boundary tick occur on the same edge, the snapshot takes the old `sys_val`. The new value is shown one frame later.
- Reset mid-frame aborts the scan immediately and returns every register to its reset value.

**Sampling**
- `led_cpu_enable` high for many cycles is legal (the CPU halts on syscall). The register reloads each cycle; the last sampled value wins.

## Configuration

**`LED_LEADING_ZERO_BLANK_EN`**
- Defined:
  - Digits above the most significant nonzero nibble of `shown` are blanked: `an[idx]`=1 and `seg`=7F for that slot.
  - Digit 0 is always displayed, so a value of 0 shows a single "0".
  - Blanking is evaluated from the same `shown` snapshot.
- Undefined: all 8 digits are always displayed, with leading zeros.

## Test plan

All scenarios use SCAN_DIV=4.

1. **Reset state.** Hold `rst`, then release. During reset `an`=FF, `seg`=7F, `dp`=1 and `data_valid`=0. The first tick comes 4 cycles after release, giving `an`=FE and `seg`=40.
2. **Latch and display.** `disp_sel`=0; pulse `led_cpu_enable` for 1 cycle with `led_data_in`=32'h1234ABCD.
   - `data_valid`=1 on the next edge.
   - Over the following full frame, `an`=FE..7F shows `seg` 21,46,03,08,19,30,24,79.
   - `dp`=0 only on digit 0.
3. **Source select.** `disp_sel`=1 with `total_cycles`=32'h00000010.
   - Defined: digits 0–1 show 40, 79; digits 2–7 are blanked.
   - Undefined: digits 2–7 show 40.
   - `dp`=1 throughout.
4. **Snapshot coherence.** Change `disp_sel` from 0 to 2 while `idx`=3. Digits 4–7 of that frame still show the syscall value; the counter appears from the next digit 0.
5. **Simultaneous latch and frame boundary.** Assert `led_cpu_enable` with 32'hFFFFFFFF on the wrap tick. The current frame shows the previous value; the next frame shows `seg`=0E on all digits.
6. **Mid-frame reset.** Assert `rst` while `idx`=5. The outputs return to their reset values the same cycle, `data_valid`=0, and after release the scan restarts at digit 0 showing 0.
